hdmi_i2c_arbiter: RTL
=====================

# hdmi_i2c_arbiter

Round-robin arbiter and transaction sequencer sharing the single HDMI I2C byte-transaction engine among NUM_REQ requesters. Typical requesters are the ADV7513 register-config sequencer, an EDID reader and a hot-plug/interrupt service agent. The arbiter accepts one 24-bit write transaction at a time and drives the engine's enable/data handshake. It enforces an inter-transaction gap and a watchdog timeout, then returns per-requester completion status.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYC, 65535, refclk cycles allowed in RUN before abort (≥4)
- GAP_CYC, 2, refclk cycles i2c_en held low between transactions (≥1)

Ports:
- refclk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request; held with req_data until req_ready
- req_data  in  24*NUM_REQ  requester i at bits [24i+23:24i]: {dev_addr, reg, value}
- req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse to the owning requester
- rsp_nack  out  1  qualified by rsp_valid: slave NACK or timeout
- rsp_timeout  out  1  qualified by rsp_valid: watchdog abort
- i2c_data  out  24  transaction word to engine, stable while i2c_en=1
- i2c_en  out  1  engine enable, level, held until end or abort
- i2c_end  in  1  engine transaction complete
- i2c_ack  in  1  engine status at i2c_end: 0 = all bytes acked, 1 = NACK
- busy  out  1  state ≠ IDLE
- grant_id  out  3  index of current/last owner

## Operation
- States: IDLE, RUN, GAP.
- IDLE: if any req_valid, pick the winner W by round-robin starting at (last+1) mod NUM_REQ. Latch req_data[W] into i2c_data, pulse req_ready[W], set grant_id=W and last=W, set i2c_en=1, clear the watchdog, go to RUN. All updates are registered on the same edge.
- RUN: the watchdog increments each cycle.
  - i2c_end=1: i2c_en←0, rsp_valid[grant_id]←1, rsp_nack←i2c_ack, rsp_timeout←0, go to GAP.
  - Watchdog reaches TIMEOUT_CYC-1 with i2c_end=0: i2c_en←0, rsp_valid pulse, rsp_nack←1, rsp_timeout←1, go to GAP.
  - i2c_end and watchdog expiry in the same cycle: end wins, timeout=0.
- GAP: count GAP_CYC cycles with i2c_en=0, then go to IDLE. Requests are not sampled in GAP.
- No retry inside the arbiter. Requesters re-request on nack.
- req_valid dropped before req_ready: the request is simply not considered. Dropping it after grant has no effect on the running transaction.
- rsp_nack and rsp_timeout hold their values until the next rsp_valid.
- Reset values:
  - state=IDLE, last=NUM_REQ-1 (requester 0 wins first).
  - i2c_en=0, i2c_data=0, req_ready=0, rsp_valid=0, rsp_nack=0, rsp_timeout=0, busy=0, grant_id=0.
  - Reset mid-transaction drops i2c_en immediately. No response is issued.

## Timing
- req_valid sampled high at edge t in IDLE: req_ready pulse and i2c_en=1 are visible after edge t. Latency is 1 cycle.
- i2c_end sampled high at edge t: rsp_valid pulse and i2c_en=0 after edge t.
- GAP occupies GAP_CYC cycles. The earliest next grant is at edge t+GAP_CYC+1.
- Back-to-back from one requester: minimum period is engine time + GAP_CYC + 2 cycles.
- Watchdog abort occurs exactly TIMEOUT_CYC cycles after the i2c_en rising edge.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- Shared package hdmi_cfg_pkg holds:
  - state encoding (IDLE/RUN/GAP)
  - I2C_WORD_W=24
  - ADV7513 device address constant 8'h72
  - default TIMEOUT_CYC
- One sub-module, rr_pick: a combinational round-robin priority picker with inputs req[NUM_REQ] and last, outputs winner index and any.
- Watchdog counter width is $clog2(TIMEOUT_CYC).

## Test plan
- Single request: req_valid[1] with data 24'h729803, engine ends after 40 cycles with ack=0. Expect req_ready[1] 1 cycle after, i2c_data=24'h729803, rsp_valid[1] with rsp_nack=0, then i2c_en low for 2 cycles.
- All three continuously valid, 6 transactions: grant order 0,1,2,0,1,2, each requester's data on i2c_data exactly during its grant.
- Engine returns ack=1: rsp_nack=1, rsp_timeout=0, and the next grant goes to the following requester, not a retry.
- Engine never asserts end, TIMEOUT_CYC=100: i2c_en falls exactly 100 cycles after rising, rsp_timeout=1, rsp_nack=1.
- i2c_end coincident with the timeout cycle: rsp_timeout=0 and rsp_nack equals i2c_ack.
- rst asserted mid-RUN: i2c_en=0 asynchronously with no rsp_valid. After release, requester 0 wins first.

Source files
------------

// File: rtl/hdmi_cfg_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_cfg_pkg
// Shared definitions for the HDMI I2C arbiter slice:
//   - arb_state_t      : arbiter FSM encoding (IDLE / RUN / GAP)
//   - I2C_WORD_W       : width of one engine transaction word {dev, reg, value}
//   - GRANT_W          : width of a requester index (up to 8 requesters)
//   - ADV7513_ADDR     : 8-bit I2C write address of the ADV7513 transmitter
//   - DEF_TIMEOUT_CYC  : default watchdog length in refclk cycles
//   - rr_dist()        : round-robin distance helper used by the picker
// -----------------------------------------------------------------------------
package hdmi_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int          I2C_WORD_W      = 24;
  localparam int          GRANT_W         = 3;
  localparam logic [7:0]  ADV7513_ADDR    = 8'h72;
  localparam int          DEF_TIMEOUT_CYC = 65535;

  // How far requester idx sits behind the last owner in the rotation:
  // last+1 gives 0, last itself gives n-1. The double modulo keeps the
  // result non-negative because SV '%' follows the sign of the dividend.
  function automatic int rr_dist(input int idx, input int last, input int n);
    return (((idx - last - 1) % n) + n) % n;
  endfunction

endpackage

// File: rtl/hdmi_i2c_arbiter_if.sv
// -----------------------------------------------------------------------------
// hdmi_i2c_arbiter_if
// Bundles the requester-side and engine-side handshakes of the arbiter.
//   req_valid/req_data/req_ready   : requester request channel
//   rsp_valid/rsp_nack/rsp_timeout : requester completion channel
//   i2c_data/i2c_en/i2c_end/i2c_ack: byte-transaction engine handshake
//   busy/grant_id                  : status
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters + engine)
// -----------------------------------------------------------------------------
interface hdmi_i2c_arbiter_if
  import hdmi_cfg_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [I2C_WORD_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_nack;
  logic                          rsp_timeout;
  logic [I2C_WORD_W-1:0]         i2c_data;
  logic                          i2c_en;
  logic                          i2c_end;
  logic                          i2c_ack;
  logic                          busy;
  logic [GRANT_W-1:0]            grant_id;

  modport slave (
    input  req_valid, req_data, i2c_end, i2c_ack,
    output req_ready, rsp_valid, rsp_nack, rsp_timeout,
           i2c_data, i2c_en, busy, grant_id
  );

  modport master (
    output req_valid, req_data, i2c_end, i2c_ack,
    input  req_ready, rsp_valid, rsp_nack, rsp_timeout,
           i2c_data, i2c_en, busy, grant_id
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting at (i_last+1) mod NUM_REQ and wraps around; i_last itself has the
// lowest priority.
// Ports:
//   i_req    : per-requester request bits
//   i_last   : index of the previous winner
//   o_winner : index of the selected requester (0 when none)
//   o_any    : at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
  import hdmi_cfg_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GRANT_W-1:0] i_last,
  output logic [GRANT_W-1:0] o_winner,
  output logic               o_any
);

  int   w_best_dist;
  int   w_dist;
  logic w_hit;

  // Keep the requesting index with the smallest rotation distance.
  always_comb begin
    o_winner    = '0;
    o_any       = 1'b0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    w_hit       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist      = rr_dist(i, int'(i_last), NUM_REQ);
      w_hit       = i_req[i] && (w_dist < w_best_dist);
      w_best_dist = w_hit ? w_dist : w_best_dist;
      o_winner    = w_hit ? GRANT_W'(i) : o_winner;
      o_any       = w_hit ? 1'b1 : o_any;
    end
  end

endmodule

// File: rtl/hdmi_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// hdmi_i2c_arbiter
// Shares the single HDMI I2C byte-transaction engine among NUM_REQ
// requesters. One 24-bit write is accepted at a time (round-robin), driven to
// the engine with a level enable, guarded by a watchdog, and followed by an
// enforced idle gap. Completion status goes back to the owning requester.
// Parameters:
//   NUM_REQ     : number of requesters (2..8)
//   TIMEOUT_CYC : refclk cycles from enable rise to watchdog abort (>=4)
//   GAP_CYC     : refclk cycles spent in GAP after each transaction (>=1)
// Ports:
//   refclk : clock
//   rst    : asynchronous active-low reset
//   bus    : hdmi_i2c_arbiter_if slave (request, response, engine, status)
// -----------------------------------------------------------------------------
module hdmi_i2c_arbiter
  import hdmi_cfg_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = 2
) (
  input  logic                refclk,
  input  logic                rst,
  hdmi_i2c_arbiter_if.slave   bus
);

  localparam int               WD_W     = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam int               GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  arb_state_t            r_state;
  logic [GRANT_W-1:0]    r_last;
  logic [WD_W-1:0]       r_wd;
  logic [GAP_W-1:0]      r_gap;
  logic [I2C_WORD_W-1:0] r_i2c_data;
  logic                  r_i2c_en;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_rsp_nack;
  logic                  r_rsp_timeout;
  logic                  r_busy;
  logic [GRANT_W-1:0]    r_grant_id;

  logic [GRANT_W-1:0]    w_win;
  logic                  w_any;
  logic [I2C_WORD_W-1:0] w_win_data;
  logic [NUM_REQ-1:0]    w_win_oh;
  logic [NUM_REQ-1:0]    w_grant_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req    (bus.req_valid),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  // Select the winner's request word and build one-hot forms of the winner
  // and of the current owner.
  always_comb begin
    w_win_data = '0;
    w_win_oh   = '0;
    w_grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_data  = (w_win == GRANT_W'(i)) ?
                    bus.req_data[i*I2C_WORD_W +: I2C_WORD_W] : w_win_data;
      w_win_oh[i]   = (w_win == GRANT_W'(i));
      w_grant_oh[i] = (r_grant_id == GRANT_W'(i));
    end
  end

  // Arbiter FSM: grant in IDLE, supervise the engine in RUN, hold off in GAP.
  // Reset is asynchronous so i2c_en drops immediately and no response is sent.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_last        <= GRANT_W'(NUM_REQ - 1);
      r_wd          <= '0;
      r_gap         <= '0;
      r_i2c_data    <= '0;
      r_i2c_en      <= 1'b0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_nack    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      // Accept and completion strobes are single-cycle.
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_i2c_data  <= w_win_data;
            r_req_ready <= w_win_oh;
            r_grant_id  <= w_win;
            r_last      <= w_win;
            r_i2c_en    <= 1'b1;
            r_wd        <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end else begin
            r_busy      <= 1'b0;
          end
        end
        ST_RUN: begin
          // Engine completion takes priority over a same-cycle watchdog expiry.
          if (bus.i2c_end) begin
            r_i2c_en      <= 1'b0;
            r_rsp_valid   <= w_grant_oh;
            r_rsp_nack    <= bus.i2c_ack;
            r_rsp_timeout <= 1'b0;
            r_gap         <= '0;
            r_state       <= ST_GAP;
          end else if (r_wd == WD_LAST) begin
            r_i2c_en      <= 1'b0;
            r_rsp_valid   <= w_grant_oh;
            r_rsp_nack    <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_gap         <= '0;
            r_state       <= ST_GAP;
          end else begin
            r_wd          <= r_wd + WD_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap   <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          r_i2c_en <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_nack    = r_rsp_nack;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.i2c_data    = r_i2c_data;
  assign bus.i2c_en      = r_i2c_en;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;

endmodule
